// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry,
// and the 2-of-3 vote used by the line filter.
package uart_pkg;

    localparam int UART_OVERSAMPLING = 8;
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sync_filter.sv
// Brings the asynchronous rxd line into the clk domain and removes
// single-tick glitches with a 2-of-3 majority vote taken on each tick.
module rx_sync_filter
    import uart_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic rxd,
    output logic rx_f
);

    logic       sync1_q;
    logic       sync2_q;
    logic [2:0] win_q;
    logic [2:0] win_d;
    logic       rx_f_q;
    logic       rx_f_d;

    // The vote includes the sample being shifted in, so two low ticks suffice.
    always_comb begin
        win_d  = {win_q[1:0], sync2_q};
        rx_f_d = majority3(win_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            win_q   <= 3'b111;
            rx_f_q  <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            if (tick) begin
                win_q  <= win_d;
                rx_f_q <= rx_f_d;
            end
        end
    end

    assign rx_f = rx_f_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start-bit detection, mid-bit sampling,
// single-cycle data_valid / frame_error strobes and break suppression.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLING = UART_OVERSAMPLING,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int TCW = $clog2(OVERSAMPLING);
    localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TCW-1:0] T_MID  = TCW'(OVERSAMPLING / 2 - 1);
    localparam logic [TCW-1:0] T_END  = TCW'(OVERSAMPLING - 1);
    localparam logic [BCW-1:0] B_LAST = BCW'(DATA_BITS - 1);

    logic                 rx_f;
    rx_state_t            state_q, state_d;
    logic [TCW-1:0]       tcnt_q, tcnt_d;
    logic [BCW-1:0]       bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 dv_q, dv_d;
    logic                 fe_q, fe_d;

    rx_sync_filter u_filt (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .rxd   (rxd),
        .rx_f  (rx_f)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            fe_q    <= fe_d;
        end
    end

    // Strobes default low every cycle so they never outlive one clk.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bcnt_d  = bcnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        fe_d    = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_f) begin
                        state_d = START;
                        tcnt_d  = '0;
                    end
                end
                START: begin
                    if (tcnt_q == T_MID) begin
                        tcnt_d  = '0;
                        bcnt_d  = '0;
                        state_d = rx_f ? IDLE : DATA;
                    end else begin
                        tcnt_d = tcnt_q + TCW'(1);
                    end
                end
                DATA: begin
                    if (tcnt_q == T_END) begin
                        tcnt_d  = '0;
                        shreg_d = {rx_f, shreg_q[DATA_BITS-1:1]};
                        if (bcnt_q == B_LAST) begin
                            state_d = STOP;
                        end else begin
                            bcnt_d = bcnt_q + BCW'(1);
                        end
                    end else begin
                        tcnt_d = tcnt_q + TCW'(1);
                    end
                end
                STOP: begin
                    if (tcnt_q == T_END) begin
                        tcnt_d = '0;
                        if (rx_f) begin
                            data_d  = shreg_q;
                            dv_d    = 1'b1;
                            state_d = IDLE;
                        end else begin
                            fe_d    = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TCW'(1);
                    end
                end
                BREAK: begin
                    if (rx_f) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy        = (state_q != IDLE);
        data        = data_q;
        data_valid  = dv_q;
        frame_error = fe_q;
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scenario bench for uart_rx: 8x oversampling, tick every 4 clk, 32 clk per bit.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int OS  = 8;
    localparam int DB  = 8;
    localparam int TPB = 4;
    localparam int BIT = OS * TPB;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          tick  = 1'b0;
    logic          rxd   = 1'b1;
    logic [DB-1:0] data;
    logic          data_valid;
    logic          frame_error;
    logic          busy;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    longint     cyc = 0;
    longint     dv_cyc[$];
    int         dv_cnt = 0;
    int         fe_cnt = 0;
    bit         both_seen = 1'b0;
    bit         long_seen = 1'b0;
    bit         busy_seen = 1'b0;
    logic       dv_prev = 1'b0;
    logic       fe_prev = 1'b0;

    uart_rx #(.OVERSAMPLING(OS), .DATA_BITS(DB)) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .rxd         (rxd),
        .data        (data),
        .data_valid  (data_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        int c;
        c = 0;
        forever begin
            @(posedge clk);
            #1;
            tick = (c == TPB - 1);
            c = (c + 1) % TPB;
        end
    end

    // Scoreboard and pulse-shape monitor
    always @(negedge clk) begin
        logic [7:0] e;
        cyc = cyc + 1;
        if (data_valid) begin
            dv_cnt = dv_cnt + 1;
            dv_cyc.push_back(cyc);
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_data_valid: data=%02h, no byte expected", data);
            end else begin
                e = exp_q.pop_front();
                if (data !== e) begin
                    errors = errors + 1;
                    $display("FAIL sb_data: got %02h expected %02h", data, e);
                end
            end
        end
        if (frame_error) fe_cnt = fe_cnt + 1;
        if (data_valid && frame_error) both_seen = 1'b1;
        if ((data_valid && dv_prev) || (frame_error && fe_prev)) long_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
        dv_prev = data_valid;
        fe_prev = frame_error;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic v, input int p);
        rxd = v;
        repeat (p) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int p, input logic stopv);
        send_bit(1'b0, p);
        for (int i = 0; i < DB; i++) send_bit(b[i], p);
        send_bit(stopv, p);
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while (busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, expected 0", busy, n);
        end
    endtask

    task automatic test_reset();
        #3 reset = 1'b1;
        #1;
        checks += 4;
        if (data !== 8'h00)      begin errors++; $display("FAIL reset_data: got %02h expected 00", data); end
        if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b expected 0", data_valid); end
        if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_fe: got %b expected 0", frame_error); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (2 * BIT) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single();
        int dv0, fe0;
        dv0 = dv_cnt; fe0 = fe_cnt;
        @(negedge clk);
        exp_q.push_back(8'h55);
        send_frame(8'h55, BIT, 1'b1);
        send_bit(1'b1, 2 * BIT);
        wait_idle(400);
        checks += 5;
        if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL single_dv_count: got %0d expected 1", dv_cnt - dv0); end
        if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL single_fe_count: got %0d expected 0", fe_cnt - fe0); end
        if (data !== 8'h55)     begin errors++; $display("FAIL single_data: got %02h expected 55", data); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL single_busy: got %b expected 0", busy); end
        if (exp_q.size() != 0)  begin errors++; $display("FAIL single_pending: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int dv0, n0;
        longint gap;
        dv0 = dv_cnt; n0 = dv_cyc.size();
        @(negedge clk);
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h3C);
        send_frame(8'hA3, BIT, 1'b1);
        send_frame(8'h3C, BIT, 1'b1);
        send_bit(1'b1, 2 * BIT);
        wait_idle(400);
        checks += 3;
        if (dv_cnt - dv0 !== 2) begin
            errors++; $display("FAIL b2b_dv_count: got %0d expected 2", dv_cnt - dv0);
        end else begin
            gap = dv_cyc[n0 + 1] - dv_cyc[n0];
            if (gap != 320) begin errors++; $display("FAIL b2b_spacing: got %0d expected 320", gap); end
        end
        if (data !== 8'h3C) begin errors++; $display("FAIL b2b_data: got %02h expected 3c", data); end
    endtask

    task automatic test_glitch();
        int dv0, fe0;
        dv0 = dv_cnt; fe0 = fe_cnt;
        @(negedge clk);
        busy_seen = 1'b0;
        send_bit(1'b0, TPB);
        send_bit(1'b1, 2 * BIT);
        checks++;
        if (busy_seen !== 1'b0) begin errors++; $display("FAIL glitch1_busy: got %b expected 0", busy_seen); end
        busy_seen = 1'b0;
        send_bit(1'b0, 3 * TPB);
        send_bit(1'b1, 2 * BIT);
        checks += 4;
        if (busy_seen !== 1'b1) begin errors++; $display("FAIL glitch3_start: got %b expected 1", busy_seen); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL glitch3_idle: got %b expected 0", busy); end
        if (dv_cnt - dv0 !== 0) begin errors++; $display("FAIL glitch_dv: got %0d expected 0", dv_cnt - dv0); end
        if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL glitch_fe: got %0d expected 0", fe_cnt - fe0); end
    endtask

    task automatic test_break();
        int dv0, fe0;
        dv0 = dv_cnt; fe0 = fe_cnt;
        @(negedge clk);
        send_frame(8'h00, BIT, 1'b0);
        send_bit(1'b0, 5 * BIT);
        checks += 4;
        if (busy !== 1'b1)      begin errors++; $display("FAIL break_busy: got %b expected 1", busy); end
        if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL break_fe_count: got %0d expected 1", fe_cnt - fe0); end
        if (dv_cnt - dv0 !== 0) begin errors++; $display("FAIL break_dv_count: got %0d expected 0", dv_cnt - dv0); end
        if (data !== 8'h3C)     begin errors++; $display("FAIL break_data: got %02h expected 3c", data); end
        rxd = 1'b1;
        wait_idle(200);
        send_bit(1'b1, 2 * BIT);
    endtask

    task automatic test_reset_mid();
        int dv0;
        @(negedge clk);
        send_bit(1'b0, BIT);
        for (int i = 0; i < 4; i++) send_bit(1'b1, BIT);
        send_bit(1'b1, BIT / 2);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy: got %b expected 1", busy); end
        #2 reset = 1'b1;
        #1;
        checks += 4;
        if (data !== 8'h00)       begin errors++; $display("FAIL areset_data: got %02h expected 00", data); end
        if (data_valid !== 1'b0)  begin errors++; $display("FAIL areset_dv: got %b expected 0", data_valid); end
        if (frame_error !== 1'b0) begin errors++; $display("FAIL areset_fe: got %b expected 0", frame_error); end
        if (busy !== 1'b0)        begin errors++; $display("FAIL areset_busy: got %b expected 0", busy); end
        repeat (4) @(negedge clk);
        reset = 1'b0;
        send_bit(1'b1, 2 * BIT);
        dv0 = dv_cnt;
        exp_q.push_back(8'h81);
        send_frame(8'h81, BIT, 1'b1);
        send_bit(1'b1, 2 * BIT);
        wait_idle(400);
        checks += 2;
        if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL post_reset_dv: got %0d expected 1", dv_cnt - dv0); end
        if (data !== 8'h81)     begin errors++; $display("FAIL post_reset_data: got %02h expected 81", data); end
    endtask

    task automatic test_skew();
        int dv0, fe0, p;
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? BIT - 1 : BIT + 1;
            dv0 = dv_cnt; fe0 = fe_cnt;
            @(negedge clk);
            exp_q.push_back(8'hC9);
            send_frame(8'hC9, p, 1'b1);
            send_bit(1'b1, 3 * p);
            wait_idle(400);
            checks += 3;
            if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL skew%0d_dv: got %0d expected 1", p, dv_cnt - dv0); end
            if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL skew%0d_fe: got %0d expected 0", p, fe_cnt - fe0); end
            if (data !== 8'hC9)     begin errors++; $display("FAIL skew%0d_data: got %02h expected c9", p, data); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_break();
        test_reset_mid();
        test_skew();
        checks += 3;
        if (both_seen !== 1'b0) begin errors++; $display("FAIL dv_fe_overlap: got %b expected 0", both_seen); end
        if (long_seen !== 1'b0) begin errors++; $display("FAIL pulse_width: got %b expected 0", long_seen); end
        if (exp_q.size() != 0)  begin errors++; $display("FAIL sb_leftover: got %0d expected 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive stage of the UART. It consumes the oversampled baud tick produced by the baud-rate tick generator (Baud × OVERSAMPLING) and the asynchronous `rxd` line. It recovers 8N1 frames and presents each received byte as a one-cycle `data_valid` pulse to the downstream command/FIFO logic. Framing violations are flagged separately and never produce a `data_valid`.

## Interface
- `OVERSAMPLING`, 8: ticks per bit period. Must be a power of two, ≥ 4.
- `DATA_BITS`, 8: data bits per frame, LSB first.
- `clk` input 1: system clock. Same clock as the tick generator.
- `reset` input 1: asynchronous, active-high reset.
- `tick` input 1: one-`clk` pulse at Baud × OVERSAMPLING, from the tick generator.
- `rxd` input 1: serial line, asynchronous to `clk`, idle high.
- `data` output DATA_BITS: last correctly framed byte. Held until the next good frame.
- `data_valid` output 1: one-`clk` pulse when `data` updates.
- `frame_error` output 1: one-`clk` pulse when the stop bit is sampled low.
- `busy` output 1: high in any state other than IDLE.

## Operation
- Synchroniser: 2-FF on `rxd`, clocked every `clk`; both flops reset to 1.
- Filter: on each `tick`, shift the synchronised bit into a 3-bit register (reset 3'b111). `rx_f` is the 2-of-3 majority, registered and updated on the same tick. `rx_f` resets to 1.
- Tick counter `tcnt`, log2(OVERSAMPLING) bits, advances only on `tick`. Bit counter `bcnt` counts 0..DATA_BITS-1.
- State machine: IDLE, START, DATA, STOP, BREAK. All transitions occur only on `tick` cycles.
  - IDLE: on `rx_f`==0, go to START with `tcnt`=0.
  - START: on `tcnt`==OVERSAMPLING/2-1 (mid start bit), check `rx_f`. If 0, go to DATA with `tcnt`=0 and `bcnt`=0. If 1, treat as a glitch and return to IDLE with no output.
  - DATA: on `tcnt`==OVERSAMPLING-1, right-shift `rx_f` into the shift register MSB, so the LSB is received first. After bit DATA_BITS-1 is sampled, go to STOP.
  - STOP: on `tcnt`==OVERSAMPLING-1, sample `rx_f`.
    - If 1: load `data` from the shift register, pulse `data_valid`, go to IDLE.
    - If 0: pulse `frame_error`, leave `data` unchanged, go to BREAK.
  - BREAK: wait for `rx_f`==1, then go to IDLE. This prevents a held-low line from producing repeated 0x00 frames.
- Back-to-back frames: a new start edge is accepted on the first tick after returning to IDLE. No extra idle time is required beyond the single stop bit.
- `data_valid` and `frame_error` are mutually exclusive and never assert in the same cycle.

## Timing
- Reset (asynchronous, any state, including mid-frame): state=IDLE, `data`=0, `data_valid`=0, `frame_error`=0, `busy`=0, all counters 0, shift register 0. Reception restarts cleanly on the next start bit after reset is released.
- `data_valid` / `frame_error` are registered outputs. They are high for exactly the one `clk` cycle after the `tick` cycle that samples the stop bit. They never last longer, even if `tick` arrives on consecutive clocks.
- Input latency: `rxd` edge to `rx_f` change is 2 `clk` (synchroniser) plus up to 2 ticks (majority filter).
- Sampling point: each bit is sampled OVERSAMPLING/2 ticks after the filtered falling edge, plus an integer number of bit periods. This gives ±(OVERSAMPLING/2 − 2) ticks of phase margin.
- `busy` rises in the cycle after the IDLE→START transition tick. It falls in the same cycle as `data_valid`/`frame_error` for a good frame. It stays high through BREAK.
- `tick` absent: state is frozen. No timeout applies.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t`.
  - Default constants `UART_OVERSAMPLING`=8 and `UART_DATA_BITS`=8, shared with the TX stage and the tick generator instantiation.
- Sub-module `rx_sync_filter` (`clk`, `reset`, `tick`, `rxd` → `rx_f`): holds the 2-FF synchroniser and the majority filter. This separates the CDC logic for lint/CDC waivers and makes the filter reusable by TX loopback checks.

## Test plan
All scenarios use OVERSAMPLING=8 and `tick` every 4 `clk`; the bit period is 32 `clk`.
- Send 0x55 with a 1 stop bit → exactly one `data_valid` pulse, `data`=0x55, `frame_error` never high, `busy` returns to 0.
- Send 0xA3 then 0x3C back-to-back with no idle gap → two `data_valid` pulses 320 `clk` apart, with `data` = 0xA3 then 0x3C.
- Drive `rxd` low for 1 tick period (glitch) → `rx_f` stays 1, no state change. Low for 3 ticks, then high before mid-start → START→IDLE, no outputs.
- Send 0x00 with the stop bit low, then hold low for 5 bit periods → a single `frame_error` pulse, `data` unchanged, `busy`=1 until the line rises, no `data_valid`.
- Assert `reset` during bit 4 of 0xFF → all outputs 0 asynchronously. Then send 0x81 → `data`=0x81, one `data_valid`.
- Skew the bit period by ±3% relative to `tick` and send 0xC9 → correct reception with no `frame_error`.
